// File: rtl/cpu_multiply_control.sv
// Sequencer between the execute stage and the pipelined multiplier: issues RV32M
// multiply ops, selects/corrects the result word, and reuses the last product on a key match.
module cpu_multiply_control #(
  parameter int MUL_LATENCY  = 4,
  parameter bit ENABLE_REUSE = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_rd,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ack,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd,
  output logic        o_mul_latch,
  output logic        o_mul_signed,
  output logic [31:0] o_mul_op1,
  output logic [31:0] o_mul_op2,
  input  logic        i_mul_ready,
  input  logic [63:0] i_mul_result
);

  localparam int GW = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {S_GUARD, S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t        state, state_d;
  logic [GW-1:0] guard_cnt;
  logic [1:0]    op_q;
  logic [31:0]   rs1_q, rs2_q, result_q;
  logic [4:0]    rd_q;
  logic          msign_q, discard_q;
  logic          reuse_vld;
  logic [64:0]   reuse_key;
  logic [63:0]   reuse_prod;
  logic          msign_in, accept, hit, mul_done;

  // MULHSU runs through the unsigned multiplier; a negative rs1 contributes -rs2 to the high word.
  function automatic logic [31:0] sel_result(input logic [1:0] op, input logic [31:0] rs1,
                                             input logic [31:0] rs2, input logic [63:0] p);
    logic [31:0] r;
    case (op)
      2'b00:   r = p[31:0];
      2'b10:   r = p[63:32] - (rs1[31] ? rs2 : 32'd0);
      default: r = p[63:32];
    endcase
    return r;
  endfunction

  assign msign_in = (i_op == 2'b01);
  assign accept   = (state == S_IDLE) && i_valid && !i_flush;
  assign hit      = ENABLE_REUSE && reuse_vld && (reuse_key == {i_rs1, i_rs2, msign_in});
  assign mul_done = (state == S_ISSUE) && i_mul_ready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_GUARD;
      guard_cnt <= GW'(MUL_LATENCY);
    end else begin
      state <= state_d;
      if (state == S_GUARD && guard_cnt != '0) guard_cnt <= guard_cnt - GW'(1);
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_GUARD: if (guard_cnt == '0) state_d = S_IDLE;
      S_IDLE:  if (accept) state_d = hit ? S_DONE : S_ISSUE;
      // The multiplier cannot cancel, so a flushed op still waits out its ready pulse.
      S_ISSUE: if (i_mul_ready) state_d = (discard_q || i_flush) ? S_IDLE : S_DONE;
      S_DONE:  if (i_flush || i_ack) state_d = S_IDLE;
      default: state_d = S_GUARD;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      op_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      msign_q    <= 1'b0;
      discard_q  <= 1'b0;
      result_q   <= '0;
      reuse_vld  <= 1'b0;
      reuse_key  <= '0;
      reuse_prod <= '0;
    end else begin
      if (accept) begin
        op_q      <= i_op;
        rs1_q     <= i_rs1;
        rs2_q     <= i_rs2;
        rd_q      <= i_rd;
        msign_q   <= msign_in;
        discard_q <= 1'b0;
        if (hit) result_q <= sel_result(i_op, i_rs1, i_rs2, reuse_prod);
      end
      if (state == S_ISSUE && i_flush) discard_q <= 1'b1;
      if (mul_done) begin
        // The key fully identifies the product, so even a discarded pass refreshes the entry.
        reuse_vld  <= 1'b1;
        reuse_key  <= {rs1_q, rs2_q, msign_q};
        reuse_prod <= i_mul_result;
        if (!(discard_q || i_flush)) result_q <= sel_result(op_q, rs1_q, rs2_q, i_mul_result);
      end
    end
  end

  assign o_ready      = (state == S_IDLE);
  assign o_valid      = (state == S_DONE);
  assign o_mul_latch  = (state == S_ISSUE);
  assign o_mul_signed = msign_q;
  assign o_mul_op1    = rs1_q;
  assign o_mul_op2    = rs2_q;
  assign o_result     = result_q;
  assign o_rd         = rd_q;

endmodule

// File: tb/tb_cpu_multiply_control.sv
// Directed bench for cpu_multiply_control with a behavioural multiplier and a result scoreboard.
module tb_cpu_multiply_control;

  localparam int MUL_LATENCY = 4;
  localparam int MISS_LAT    = MUL_LATENCY + 1;

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        i_valid = 1'b0, i_flush = 1'b0, i_ack = 1'b0;
  logic [1:0]  i_op = '0;
  logic [31:0] i_rs1 = '0, i_rs2 = '0;
  logic [4:0]  i_rd = '0;
  logic        o_ready, o_valid, o_mul_latch, o_mul_signed;
  logic [31:0] o_result, o_mul_op1, o_mul_op2;
  logic [4:0]  o_rd;
  logic        i_mul_ready = 1'b0;
  logic [63:0] i_mul_result = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int rises    = 0;
  logic [36:0] exp_q[$];

  cpu_multiply_control #(.MUL_LATENCY(MUL_LATENCY), .ENABLE_REUSE(1'b1)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_flush(i_flush),
    .o_valid(o_valid), .i_ack(i_ack), .o_result(o_result), .o_rd(o_rd),
    .o_mul_latch(o_mul_latch), .o_mul_signed(o_mul_signed),
    .o_mul_op1(o_mul_op1), .o_mul_op2(o_mul_op2),
    .i_mul_ready(i_mul_ready), .i_mul_result(i_mul_result)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [63:0] mprod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb, p;
    sa = s ? {{32{a[31]}}, a} : {32'd0, a};
    sb = s ? {{32{b[31]}}, b} : {32'd0, b};
    p  = sa * sb;
    return p;
  endfunction

  // Architectural RV32M result, computed with true operand extension per op.
  function automatic logic [31:0] mul_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier model: sees the latch rise one edge after assertion, pulses ready MUL_LATENCY edges later.
  int   mcnt = 0;
  logic lprev = 1'b0, ms = 1'b0;
  logic [31:0] ma = '0, mb = '0;
  always @(posedge i_clock) begin
    i_mul_ready <= 1'b0;
    if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        i_mul_ready  <= 1'b1;
        i_mul_result <= mprod(ma, mb, ms);
      end
    end else if (o_mul_latch && !lprev) begin
      mcnt <= MUL_LATENCY - 1;
      ma <= o_mul_op1;
      mb <= o_mul_op2;
      ms <= o_mul_signed;
    end
    if (o_mul_latch && !lprev) rises <= rises + 1;
    lprev <= o_mul_latch;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock); #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push);
    int n = 0;
    i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_rd = rd;
    while (!o_ready && n < 50) begin step(); n++; end
    check("accept_ready", o_ready, 1'b1);
    step();
    i_valid = 1'b0;
    if (push) exp_q.push_back({rd, mul_ref(op, a, b)});
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 50) begin step(); lat++; end
  endtask

  task automatic take_result();
    logic [36:0] e;
    check("valid_before_ack", o_valid, 1'b1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 37'h0;
    check("result", o_result, e[31:0]);
    check("rd", o_rd, e[36:32]);
    check("latch_low_in_done", o_mul_latch, 1'b0);
    i_ack = 1'b1;
    step();
    i_ack = 1'b0;
    check("valid_after_ack", o_valid, 1'b0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hit);
    int r0, lat;
    r0 = rises;
    issue(op, a, b, rd, 1'b1);
    if (!hit) begin
      check("latch_in_issue", o_mul_latch, 1'b1);
      check("signed_mode", o_mul_signed, op == 2'b01);
      check("mul_op1", o_mul_op1, a);
      check("mul_op2", o_mul_op2, b);
    end
    wait_valid(lat);
    check("latency", lat, hit ? 0 : MISS_LAT);
    if (hit) check("no_latch_rise", rises, r0);
    take_result();
  endtask

  initial begin
    int lat, n, vseen;
    logic [36:0] e;

    // Power-up reset and guard window
    #2 i_reset_n = 1'b0;
    #1;
    check("rst_ready", o_ready, 1'b0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_latch", o_mul_latch, 1'b0);
    check("rst_result", o_result, 32'h0);
    check("rst_rd", o_rd, 5'h0);
    step(); step();
    i_reset_n = 1'b1;
    for (int k = 0; k < MUL_LATENCY; k++) begin step(); check("guard_ready", o_ready, 1'b0); end
    n = 0;
    while (!o_ready && n < 10) begin step(); n++; end
    check("guard_exit", o_ready, 1'b1);

    // Flush in IDLE blocks the accept
    i_valid = 1'b1; i_flush = 1'b1; i_op = 2'b00; i_rs1 = 32'h5; i_rs2 = 32'h7;
    step();
    check("idle_flush_ready", o_ready, 1'b1);
    check("idle_flush_latch", o_mul_latch, 1'b0);
    i_valid = 1'b0; i_flush = 1'b0;

    // MULH signed then MUL on the same operands misses (different sign key)
    run_op(2'b01, 32'hFFFFFFFE, 32'h00000003, 5'd1, 1'b0);
    check("mulh_val", mul_ref(2'b01, 32'hFFFFFFFE, 32'h3), 32'hFFFFFFFF);
    run_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 5'd2, 1'b0);

    // MULHU miss, then MUL and MULHSU on the same operands hit the reuse entry
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b0);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 1'b1);
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1'b1);
    run_op(2'b10, 32'h00000002, 32'h80000000, 5'd6, 1'b0);

    // Back-to-back with ack withheld: output held, next op not accepted
    issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 5'd7, 1'b1);
    wait_valid(lat);
    check("b2b_latency", lat, MISS_LAT);
    e = exp_q[0];
    i_valid = 1'b1; i_op = 2'b01; i_rs1 = 32'h80000000; i_rs2 = 32'h7FFFFFFF; i_rd = 5'd8;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_valid", o_valid, 1'b1);
      check("hold_result", o_result, e[31:0]);
      check("hold_rd", o_rd, e[36:32]);
      check("hold_ready", o_ready, 1'b0);
    end
    take_result();
    check("gap_latch_low", o_mul_latch, 1'b0);
    run_op(2'b01, 32'h80000000, 32'h7FFFFFFF, 5'd8, 1'b0);

    // Flush one cycle into a miss: latch held to the ready pulse, no result
    issue(2'b00, 32'h00001111, 32'h00002222, 5'd9, 1'b0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("flush_latch_held", o_mul_latch, 1'b1);
    n = 0; vseen = 0;
    while (!o_ready && n < 20) begin step(); n++; if (o_valid) vseen++; end
    check("flush_ready_back", o_ready, 1'b1);
    check("flush_no_valid", vseen, 0);
    run_op(2'b00, 32'h00001111, 32'h00002222, 5'd10, 1'b1);

    // Flush beats a simultaneous ack in DONE
    issue(2'b11, 32'h00001111, 32'h00002222, 5'd11, 1'b1);
    check("done_hit_valid", o_valid, 1'b1);
    i_flush = 1'b1; i_ack = 1'b1;
    step();
    i_flush = 1'b0; i_ack = 1'b0;
    check("done_flush_valid", o_valid, 1'b0);
    check("done_flush_ready", o_ready, 1'b1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());

    // Reset two cycles after issue: stale ready pulse absorbed by the guard
    issue(2'b11, 32'hDEADBEEF, 32'h01234567, 5'd12, 1'b0);
    step(); step();
    i_reset_n = 1'b0;
    #1;
    check("midrst_valid", o_valid, 1'b0);
    check("midrst_ready", o_ready, 1'b0);
    check("midrst_latch", o_mul_latch, 1'b0);
    check("midrst_result", o_result, 32'h0);
    check("midrst_rd", o_rd, 5'h0);
    step();
    i_reset_n = 1'b1;
    vseen = 0;
    for (int k = 0; k < MUL_LATENCY; k++) begin
      step();
      check("midrst_guard", o_ready, 1'b0);
      if (o_valid || o_mul_latch) vseen++;
    end
    check("midrst_quiet", vseen, 0);
    run_op(2'b11, 32'hDEADBEEF, 32'h01234567, 5'd13, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
